// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO between two requesters, with an optional
// per-requester lock and an owner-tagged read return path.
module lifo_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_push,
  input  logic             req1_push,
  input  logic             req0_pop,
  input  logic             req1_pop,
  input  logic [WIDTH-1:0] req0_din,
  input  logic [WIDTH-1:0] req1_din,
  input  logic             lock0,
  input  logic             lock1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             lifo_push,
  output logic             lifo_pop,
  output logic [WIDTH-1:0] lifo_din,
  input  logic [WIDTH-1:0] lifo_dout,
  input  logic             lifo_full,
  input  logic             lifo_empty
);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             rvalid_q;
  logic             owner_q;
  logic [WIDTH-1:0] hold0_q, hold1_q;

  logic [1:0] push_ok, pop_ok, elig, lock;
  logic       gnt_any, gnt_sel;

  assign push_ok = {req1_push, req0_push} & {2{~lifo_full}};
  assign pop_ok  = {req1_pop, req0_pop} & {2{~lifo_empty}};
  assign elig    = push_ok | pop_ok;
  assign lock    = {lock1, lock0};

  always_comb begin
    gnt_any   = 1'b0;
    gnt_sel   = 1'b0;
    state_d   = state_q;
    last_d    = last_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    lifo_push = 1'b0;
    lifo_pop  = 1'b0;
    lifo_din  = '0;

    unique case (state_q)
      ARB: begin
        if (elig[0] && elig[1]) begin
          gnt_any = 1'b1;
          gnt_sel = ~last_q;
        end else if (elig[0]) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end else if (elig[1]) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end
      end
      LOCK0: begin
        gnt_any = elig[0];
        gnt_sel = 1'b0;
      end
      LOCK1: begin
        gnt_any = elig[1];
        gnt_sel = 1'b1;
      end
      default: ;
    endcase

    if (!reset_n) gnt_any = 1'b0;

    // Push wins over a simultaneous pop from the same requester.
    if (gnt_any) begin
      gnt0   = ~gnt_sel;
      gnt1   = gnt_sel;
      last_d = gnt_sel;
      if (push_ok[gnt_sel]) begin
        lifo_push = 1'b1;
        lifo_din  = gnt_sel ? req1_din : req0_din;
      end else begin
        lifo_pop  = 1'b1;
      end
    end

    unique case (state_q)
      ARB: begin
        if (gnt_any && lock[gnt_sel]) state_d = gnt_sel ? LOCK1 : LOCK0;
      end
      LOCK0: begin
        if (!lock0) begin
          state_d = ARB;
          last_d  = 1'b0;
        end
      end
      LOCK1: begin
        if (!lock1) begin
          state_d = ARB;
          last_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ARB;
      last_q   <= 1'b1;
      rvalid_q <= 1'b0;
      owner_q  <= 1'b0;
      hold0_q  <= '0;
      hold1_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= lifo_pop;
      if (lifo_pop) owner_q <= gnt_sel;
      if (rvalid_q && !owner_q) hold0_q <= lifo_dout;
      if (rvalid_q &&  owner_q) hold1_q <= lifo_dout;
    end
  end

  // LIFO data is valid in the return cycle, so it is passed through then and held after.
  assign rvalid0 = rvalid_q & ~owner_q;
  assign rvalid1 = rvalid_q &  owner_q;
  assign rdata0  = rvalid0 ? lifo_dout : hold0_q;
  assign rdata1  = rvalid1 ? lifo_dout : hold1_q;

endmodule

// File: doc/lifo_arbiter.md
# lifo_arbiter

Round-robin arbiter that shares one LIFO stack between two requesters. It sits between two client ports and the `lifo` instance. Each cycle it selects at most one push or pop, drives the LIFO controls and returns popped data to the requester that issued the pop. An optional lock lets one requester own the stack for a burst of operations.

## Interface
- `WIDTH`, 8, data width; must equal the LIFO data width.
- `clk`  in  1  rising-edge clock for all state.
- `reset_n`  in  1  synchronous, active-low reset.
- `req0_push`, `req1_push`  in  1  push request; held until granted.
- `req0_pop`, `req1_pop`  in  1  pop request; held until granted.
- `req0_din`, `req1_din`  in  WIDTH  push data; stable while the push request is held.
- `lock0`, `lock1`  in  1  ownership request for a burst.
- `gnt0`, `gnt1`  out  1  combinational; the request is accepted this cycle.
- `rvalid0`, `rvalid1`  out  1  registered; popped data is valid for the owner.
- `rdata0`, `rdata1`  out  WIDTH  popped data, qualified by the matching `rvalid`.
- `lifo_push`, `lifo_pop`  out  1  LIFO controls.
- `lifo_din`  out  WIDTH  LIFO write data.
- `lifo_dout`  in  WIDTH  LIFO read data; valid the cycle after `lifo_pop`.
- `lifo_full`, `lifo_empty`  in  1  registered LIFO status.

## Operation
- **Eligibility.** A push request is eligible only when `lifo_full`=0. A pop request is eligible only when `lifo_empty`=0. Ineligible requests wait and are never dropped.
- **Simultaneous push and pop from one requester.** Push is considered first. The pop stays pending for a later cycle.
- **One operation per cycle.** At most one `gnt` is high in any cycle.
- **LIFO controls.**
  - `lifo_push` = the granted push.
  - `lifo_pop` = the granted pop.
  - `lifo_din` = the granted requester's din; 0 when no push is granted.
- **Round-robin pointer `last`.**
  - Holds the index of the most recently granted requester.
  - When both requesters are eligible, the one that is not `last` wins.
  - When only one requester is eligible, it wins.
  - `last` updates on every grant.
- **FSM states.**
  - **ARB** (reset state): round-robin as above. A grant to k with `lock_k`=1 moves the FSM to LOCK_k.
  - **LOCK0 / LOCK1:** only requester k can be granted; the other requester waits even if it is eligible. When `lock_k`=0 is sampled, the FSM returns to ARB on the next edge and `last`=k. Deasserting lock in the same cycle as a grant is legal.
- **Read return.**
  - A pop granted to k in cycle N gives `rvalid_k`=1 and `rdata_k`=`lifo_dout` in cycle N+1.
  - A 1-bit owner tag is registered with the pop.
  - The non-owner's `rvalid` is 0.
  - `rdata` holds its last value when `rvalid` is 0.
- **Reset.**
  - Synchronous and active-low; it overrides everything, including mid-burst and pending read return.
  - While `reset_n`=0: `gnt*`=0, `lifo_push`=0, `lifo_pop`=0, `lifo_din`=0.
  - After the reset edge: state=ARB, `last`=1 (requester 0 has first priority), `rvalid*`=0, `rdata*`=0, owner tag=0.

## Timing
- Request to grant takes 0 cycles: `gnt` is combinational from the requests, `lifo_full`/`lifo_empty`, the state and `last`.
- The requester drops or changes its request in the cycle after `gnt`.
- Pop to data takes 1 cycle. Back-to-back pops produce back-to-back `rvalid`, with no bubbles.
- Full and empty are evaluated on the current registered flags.
  - A push when the stack holds DEPTH-1 entries is granted; the next push waits until a pop occurs.
  - A pop when the stack holds 1 entry is granted; a following pop waits.
- Lock handover: the lock is released at edge N, ARB is active in cycle N+1, and the other requester can be granted in N+1.
- Throughput: one LIFO operation per cycle, sustained.

## Test plan
- **Reset.** Hold `reset_n`=0 for 2 cycles with all requests high → `gnt*`, `lifo_push`/`lifo_pop`, `rvalid*` all 0. After release, the first contended grant goes to requester 0.
- **Contention.**
  - Stimulus: requester 0 pushes 0x01 and requester 1 pushes 0x02, both held continuously, on an empty stack.
  - Required grants: 0, 1, 0, 1 alternating.
  - Then requester 1 pops twice → `rvalid1` with 0x02, then 0x01, each 1 cycle after its grant. `rvalid0` stays 0.
- **Boundaries.**
  - Fill a DEPTH=64 stack via requester 0. A 65th push is held with no grant while `lifo_full`=1.
  - A pop by requester 1 is then granted, and the held push is granted the next cycle.
  - A pop on an empty stack gets no grant and no `rvalid`.
- **Lock.**
  - Requester 1 asserts `lock1` and pushes 0xA0, 0xA1, 0xA2 while requester 0 requests a push continuously → requester 0 gets no grant until `lock1` is sampled 0. Requester 0 is granted in the following cycle.
  - Popping after the burst returns 0xA2 first.
- **Same-requester conflict.** Requester 0 asserts push 0x55 and pop together on a non-empty stack → the push is granted first, then the pop, which returns 0x55.
- **Reset mid-operation.** Assert `reset_n`=0 in the cycle after a pop grant → `rvalid` is 0 after the edge, the FSM leaves LOCK to ARB, and no LIFO strobe is driven during reset.
